fifo_wptr_full: RTL and testbench
=================================

Name: fifo_wptr_full

Overview:
Write-domain pointer and status generator for the async FIFO. It drives the Gray-coded write pointer that the write-to-read synchronizer carries into the read domain. It consumes the read pointer after that pointer has passed through the read-to-write synchronizer. From these it produces the memory write address/enable, Full, Almost_Full, a pessimistic fill count and a sticky overflow flag.

Parameters:
WIDTH, 8, address bits; FIFO depth = 2^WIDTH; pointers are WIDTH+1 bits (bit WIDTH = wrap bit); WIDTH >= 2
AF_LEVEL, 252, Almost_Full threshold in words; legal range 1..2^WIDTH

Ports:
CLK  in  1  write-domain clock; all state updates on posedge
RST_n  in  1  synchronous active-low reset, sampled on posedge CLK
W_Inc  in  1  write request; one word per cycle while asserted
Clr_Ovf  in  1  clears Overflow
RQ2_Ptr  in  WIDTH+1  read pointer, Gray, already synchronized into CLK domain
W_Addr  out  WIDTH  memory write address = binary write pointer [WIDTH-1:0]
W_En  out  1  memory write enable (combinational)
W_Ptr  out  WIDTH+1  registered Gray write pointer, to synchronizer D_In
Full  out  1  registered full flag
Almost_Full  out  1  registered, W_Count >= AF_LEVEL
W_Count  out  WIDTH+1  registered fill level seen by write side, 0..2^WIDTH
Overflow  out  1  sticky write-while-full error

Behaviour:
- Reset: on posedge CLK with RST_n=0, set Wbin, W_Ptr, Full, Almost_Full, W_Count and Overflow to 0. W_Addr follows to 0.
- Reset timing: reset takes priority over all other inputs. A reset mid-operation discards pointer state. The read domain must be reset in the same window; this is system-level, not checked here.
- W_En = W_Inc & ~Full & RST_n. This is purely combinational and has no cycle latency. A write is accepted on any edge where W_En=1.
- Internal binary pointer Wbin [WIDTH:0] is registered:
  - Wbin_next = Wbin + W_En, modulo 2^(WIDTH+1).
  - Natural wrap from all-ones to 0.
- Gray encoding: Wgray_next = (Wbin_next >> 1) ^ Wbin_next. W_Ptr <= Wgray_next. W_Ptr is registered with no glitches and changes at most one bit per edge. These two properties are mandatory for safe synchronization.
- Full: Full <= (Wgray_next == {~RQ2_Ptr[WIDTH:WIDTH-1], RQ2_Ptr[WIDTH-2:0]}).
  - Full is computed from next-state values, so it asserts on the same edge as the write that fills the FIFO.
  - It never lags by a cycle, and the FIFO never accepts a 2^WIDTH+1-th word.
- Read-pointer conversion: Rbin = Gray-to-binary of RQ2_Ptr (prefix XOR from the MSB down). This is combinational.
- Fill count: W_Count <= Wbin_next - Rbin, modulo 2^(WIDTH+1).
  - Unsigned result; maximum 2^WIDTH when Full.
  - Pessimistic: it lags real reads by the synchronizer latency, and never under-reports.
- Almost_Full: Almost_Full <= (Wbin_next - Rbin) >= AF_LEVEL. It is registered alongside W_Count.
- Full release: Full deasserts on the first edge where RQ2_Ptr has advanced, i.e. 2 read-clock plus 2 write-clock delays after a read.
- Overflow:
  - Set on the edge where W_Inc & Full & RST_n.
  - Cleared on the edge where Clr_Ovf=1 and no set condition is present.
  - When set and clear occur on the same edge, set wins.
  - An overflowed write changes no other state.
- Simultaneous events: a write and a read-pointer advance on the same edge are both reflected in the next-state Full and W_Count (net change 0).
- RQ2_Ptr must be a valid Gray value. No checking of multi-bit jumps is required.

Test Plan:
1. Reset: hold RST_n=0 for 3 edges with W_Inc=1 and RQ2_Ptr=0 -> W_En=0; W_Ptr=0, W_Addr=0, Full=0, Almost_Full=0, W_Count=0, Overflow=0.
2. Fill: RQ2_Ptr=0, W_Inc=1 for 256 cycles ->
   - After the 252nd write: Almost_Full=1, W_Count=252.
   - After the 256th write, on the same edge: Full=1, W_Count=256, W_Ptr=9'h180, W_Addr=0.
3. Overflow: with Full=1, W_Inc=1 for 2 cycles -> W_En=0, W_Ptr stays 9'h180, Overflow=1. Then Clr_Ovf=1 with W_Inc=0 -> Overflow=0 next edge.
4. Set-vs-clear priority: with Full=1, drive W_Inc=1 and Clr_Ovf=1 on the same edge -> Overflow=1.
5. Drain: with Full=1, set RQ2_Ptr=9'h001 (binary 1) -> next edge Full=0 and W_Count=255. One write then refills: Full=1, W_Ptr=9'h181.
6. Wrap/Gray: RQ2_Ptr tracks W_Ptr delayed 4 cycles, W_Inc=1 for 600 cycles ->
   - Full never asserts.
   - Every W_Ptr change flips exactly one bit.
   - Binary 511 (9'h100) is followed by 0.
   - W_Count stays at 4 in steady state.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full
// Write-domain half of an asynchronous FIFO. It owns the binary and Gray
// write pointers and turns the synchronized read pointer into Full,
// Almost_Full, a pessimistic fill count and a sticky overflow flag.
// All status flags are computed from next-state pointer values. This lets
// them assert on the same edge as the write that causes them.

module fifo_wptr_full #(
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 252
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             W_Inc,
  input  logic             Clr_Ovf,
  input  logic [WIDTH:0]   RQ2_Ptr,
  output logic [WIDTH-1:0] W_Addr,
  output logic             W_En,
  output logic [WIDTH:0]   W_Ptr,
  output logic             Full,
  output logic             Almost_Full,
  output logic [WIDTH:0]   W_Count,
  output logic             Overflow
);

  // Threshold and increment sized to the pointer width so every compare
  // and add below stays width-matched.
  localparam logic [WIDTH:0] AfLevel = (WIDTH+1)'(AF_LEVEL);
  localparam logic [WIDTH:0] OneVal  = (WIDTH+1)'(1);

  logic [WIDTH:0] wbin_q;
  logic [WIDTH:0] wbin_d;
  logic [WIDTH:0] wgray_q;
  logic [WIDTH:0] wgray_d;
  logic [WIDTH:0] rbin;
  logic [WIDTH:0] fullCmp;
  logic [WIDTH:0] fill_d;
  logic [WIDTH:0] count_q;
  logic           full_q;
  logic           full_d;
  logic           almostFull_q;
  logic           almostFull_d;
  logic           overflow_q;
  logic           overflow_d;
  logic           ovfSet;

  // Write acceptance. Reset also gates the enable, so memory is never written during reset.
  always_comb begin
    W_En = W_Inc & ~full_q & RST_n;
  end

  // Next binary pointer and its Gray image. The Gray value is registered
  // directly, so the synchronizer only ever sees single-bit steps.
  always_comb begin
    wbin_d  = wbin_q + (W_En ? OneVal : '0);
    wgray_d = (wbin_d >> 1) ^ wbin_d;
  end

  // Gray-to-binary of the synchronized read pointer. Each binary bit is
  // the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      rbin[i] = ^(RQ2_Ptr >> i);
    end
  end

  // Status next-state. The write pointer is exactly one lap ahead of the read pointer
  // when the two top Gray bits differ and the rest match.
  always_comb begin
    fullCmp      = {~RQ2_Ptr[WIDTH:WIDTH-1], RQ2_Ptr[WIDTH-2:0]};
    full_d       = (wgray_d == fullCmp);
    fill_d       = wbin_d - rbin;
    almostFull_d = (fill_d >= AfLevel);
  end

  // Sticky overflow. A rejected write sets it, and set beats a simultaneous clear.
  always_comb begin
    ovfSet     = W_Inc & full_q & RST_n;
    overflow_d = ovfSet | (overflow_q & ~Clr_Ovf);
  end

  // Pointer and status registers, with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      wbin_q       <= '0;
      wgray_q      <= '0;
      full_q       <= 1'b0;
      almostFull_q <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wbin_q       <= wbin_d;
      wgray_q      <= wgray_d;
      full_q       <= full_d;
      almostFull_q <= almostFull_d;
      count_q      <= fill_d;
      overflow_q   <= overflow_d;
    end
  end

  // Output wiring. Everything except W_En comes straight from a register.
  always_comb begin
    W_Addr      = wbin_q[WIDTH-1:0];
    W_Ptr       = wgray_q;
    Full        = full_q;
    Almost_Full = almostFull_q;
    W_Count     = count_q;
    Overflow    = overflow_q;
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full
// Directed and randomized checks of the write-side pointer block against an
// occupancy model. The model tracks words written and words read as plain
// counters, and derives the expected outputs from them.

module tb_fifo_wptr_full;

  localparam int W     = 8;
  localparam int DEPTH = 256;
  localparam int AF    = 252;

  logic         CLK;
  logic         RST_n;
  logic         W_Inc;
  logic         Clr_Ovf;
  logic [W:0]   RQ2_Ptr;
  logic [W-1:0] W_Addr;
  logic         W_En;
  logic [W:0]   W_Ptr;
  logic         Full;
  logic         Almost_Full;
  logic [W:0]   W_Count;
  logic         Overflow;

  int testCount = 0;
  int failCount = 0;

  // model state: pointers as counts modulo 2*DEPTH
  int unsigned wrM    = 0;
  int unsigned rdM    = 0;
  logic        fullM  = 1'b0;
  logic        afM    = 1'b0;
  int unsigned cntM   = 0;
  logic        ovfM   = 1'b0;
  logic [W:0]  prevPtr = '0;
  bit          anyFull = 0;

  fifo_wptr_full #(.WIDTH(W), .AF_LEVEL(AF)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .W_Inc      (W_Inc),
    .Clr_Ovf    (Clr_Ovf),
    .RQ2_Ptr    (RQ2_Ptr),
    .W_Addr     (W_Addr),
    .W_En       (W_En),
    .W_Ptr      (W_Ptr),
    .Full       (Full),
    .Almost_Full(Almost_Full),
    .W_Count    (W_Count),
    .Overflow   (Overflow)
  );

  // free-running write clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [W:0] toGray(int unsigned b);
    logic [W:0] v;
    v = (W+1)'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic checkBit(string tag, logic got, logic exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkVec(string tag, logic [W:0] got, logic [W:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // compare every registered output against the model
  task automatic checkOutput(string tag);
    checkVec({tag, ".W_Ptr"},   W_Ptr, toGray(wrM));
    checkVec({tag, ".W_Addr"},  {1'b0, W_Addr}, (W+1)'(wrM % DEPTH));
    checkBit({tag, ".Full"},    Full, fullM);
    checkBit({tag, ".AFull"},   Almost_Full, afM);
    checkVec({tag, ".W_Count"}, W_Count, (W+1)'(cntM));
    checkBit({tag, ".Ovf"},     Overflow, ovfM);
  endtask

  // one clock: drive inputs, check W_En, advance model with the edge, check outputs
  task automatic applyStimulus(string tag, logic rstn, logic inc, logic clr, int unsigned rd);
    logic expEn;
    logic ovfSet;
    int unsigned fill;
    RST_n   = rstn;
    W_Inc   = inc;
    Clr_Ovf = clr;
    rdM     = rd % (2 * DEPTH);
    RQ2_Ptr = toGray(rdM);
    #1;
    expEn = inc && !fullM && rstn;
    checkBit({tag, ".W_En"}, W_En, expEn);
    prevPtr = W_Ptr;
    @(posedge CLK);
    if (!rstn) begin
      wrM = 0; ovfM = 0; fullM = 0; afM = 0; cntM = 0;
    end else begin
      ovfSet = inc && fullM;
      if (expEn) wrM = (wrM + 1) % (2 * DEPTH);
      ovfM  = ovfSet ? 1'b1 : (clr ? 1'b0 : ovfM);
      fill  = (wrM + 2 * DEPTH - rdM) % (2 * DEPTH);
      cntM  = fill;
      fullM = (fill == DEPTH);
      afM   = (fill >= AF);
    end
    #1;
    checkOutput(tag);
    if (Full) anyFull = 1;
    if (rstn && (W_Ptr !== prevPtr)) begin
      testCount++;
      assert ($countones(W_Ptr ^ prevPtr) == 1) else begin
        failCount++;
        $error("[TB] FAIL %s.gray_step got=%h->%h exp=one bit change", tag, prevPtr, W_Ptr);
      end
    end
  endtask

  initial begin
    int unsigned rd;
    RST_n = 1'b0; W_Inc = 1'b0; Clr_Ovf = 1'b0; RQ2_Ptr = '0;

    // 1. reset held with a write request pending
    for (int i = 0; i < 3; i++) applyStimulus("reset", 1'b0, 1'b1, 1'b0, 0);

    // 2. fill from empty
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus("fill", 1'b1, 1'b1, 1'b0, 0);
      if (i == AF) begin
        checkBit("fill252.AFull", Almost_Full, 1'b1);
        checkVec("fill252.W_Count", W_Count, 9'd252);
      end
      if (i == DEPTH - 1) checkBit("fill255.Full", Full, 1'b0);
    end
    checkBit("fill256.Full", Full, 1'b1);
    checkVec("fill256.W_Count", W_Count, 9'd256);
    checkVec("fill256.W_Ptr", W_Ptr, 9'h180);
    checkVec("fill256.W_Addr", {1'b0, W_Addr}, 9'h000);

    // 3. writes while full set overflow; a clear alone drops it
    applyStimulus("ovf1", 1'b1, 1'b1, 1'b0, 0);
    applyStimulus("ovf2", 1'b1, 1'b1, 1'b0, 0);
    checkVec("ovf.W_Ptr", W_Ptr, 9'h180);
    checkBit("ovf.Ovf", Overflow, 1'b1);
    applyStimulus("ovfclr", 1'b1, 1'b0, 1'b1, 0);
    checkBit("ovfclr.Ovf", Overflow, 1'b0);

    // 4. set and clear on the same edge: set wins
    applyStimulus("setclr", 1'b1, 1'b1, 1'b1, 0);
    checkBit("setclr.Ovf", Overflow, 1'b1);

    // 5. one read seen, then one write refills
    applyStimulus("drain", 1'b1, 1'b0, 1'b0, 1);
    checkBit("drain.Full", Full, 1'b0);
    checkVec("drain.W_Count", W_Count, 9'd255);
    applyStimulus("refill", 1'b1, 1'b1, 1'b0, 1);
    checkBit("refill.Full", Full, 1'b1);
    checkVec("refill.W_Ptr", W_Ptr, 9'h181);

    // 6. long streaming run with the reader trailing by the synchronizer delay
    applyStimulus("wrapRst", 1'b0, 1'b0, 1'b0, 0);
    anyFull = 0;
    for (int i = 0; i < 600; i++) begin
      rd = (wrM >= 3) ? wrM - 3 : 0;
      applyStimulus("wrap", 1'b1, 1'b1, 1'b0, rd);
      if (prevPtr == 9'h100) checkVec("wrap.511to0", W_Ptr, 9'h000);
    end
    checkBit("wrap.neverFull", anyFull, 1'b0);
    checkVec("wrap.steadyCount", W_Count, 9'd4);

    // 7. randomized traffic with occasional resets and clears
    applyStimulus("rndRst", 1'b0, 1'b0, 1'b0, 0);
    rd = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rstn;
      logic inc;
      logic clr;
      int unsigned occ;
      rstn = ($urandom_range(0, 299) != 0);
      inc  = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      occ  = (wrM + 2 * DEPTH - rdM) % (2 * DEPTH);
      if (occ > 0 && $urandom_range(0, 2) < ((i < 1500) ? 1 : 2)) rd = rdM + 1;
      else rd = rdM;
      if (!rstn) rd = 0;
      applyStimulus("rand", rstn, inc, clr, rd);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // absolute time bound so the bench always ends
  initial begin
    #2000000;
    $display("[TB] FAIL timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
